// File: rtl/riscv_disp_pkg.sv
// Shared constants for the seven-segment result display: glyphs,
// display-state encoding and the default fail sentinel.
package riscv_disp_pkg;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_I     = 7'b1111001;
  localparam logic [6:0] SEG_L     = 7'b1000111;

  localparam logic [31:0] FAIL_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DISP_BLANK,
    DISP_SHOW,
    DISP_FAIL
  } disp_state_e;

  // Hex digit 0..F to active-low segment pattern
  function automatic logic [6:0] seg7_glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to active-low seven-segment decoder.
module hex_to_seg7
  import riscv_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Pure table lookup, no state
  always_comb begin
    seg_o = seg7_glyph(nibble_i);
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Result display: captures the core's 32-bit result on a valid strobe and
// shows one 16-bit half at a time on four active-low digits. A fail
// sentinel value switches to a blinking "FAIL" message. Outputs are flops.
module hex_display_ctrl
  import riscv_disp_pkg::*;
#(
  parameter int unsigned PAGE_TICKS  = 50_000_000,
  parameter int unsigned BLINK_TICKS = 12_500_000,
  parameter bit          AUTO_SCROLL = 1'b1,
  parameter logic [31:0] FAIL_WORD   = FAIL_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  input  logic        page_btn_i,
  output logic [6:0]  hex0_o,
  output logic [6:0]  hex1_o,
  output logic [6:0]  hex2_o,
  output logic [6:0]  hex3_o
);

  localparam int unsigned PW = $clog2(PAGE_TICKS);
  localparam int unsigned BW = $clog2(BLINK_TICKS);
  localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGE_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  disp_state_e   state_q, state_d;
  logic [31:0]   cap_q, cap_d;
  logic          page_q, page_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          btn_q;
  logic [6:0]    hex0_d, hex1_d, hex2_d, hex3_d;

  logic          btn_edge;
  logic          page_wrap;
  logic [15:0]   half;
  logic [6:0]    seg0, seg1, seg2, seg3;

  assign half = page_q ? cap_q[31:16] : cap_q[15:0];

  hex_to_seg7 u_dig0 (.nibble_i(half[3:0]),   .seg_o(seg0));
  hex_to_seg7 u_dig1 (.nibble_i(half[7:4]),   .seg_o(seg1));
  hex_to_seg7 u_dig2 (.nibble_i(half[11:8]),  .seg_o(seg2));
  hex_to_seg7 u_dig3 (.nibble_i(half[15:12]), .seg_o(seg3));

  // Next-state: capture, display mode, paging and blink timing
  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    page_d    = page_q;
    pcnt_d    = pcnt_q;
    bcnt_d    = bcnt_q;
    phase_d   = phase_q;
    btn_edge  = page_btn_i & ~btn_q;
    page_wrap = (state_q != DISP_BLANK) && (pcnt_q == PAGE_LAST);

    if (state_q != DISP_BLANK) begin
      pcnt_d = page_wrap ? '0 : pcnt_q + 1'b1;
    end

    // A button edge coinciding with a wrap still yields one toggle
    if (btn_edge) begin
      page_d = ~page_q;
      pcnt_d = '0;
    end else if (page_wrap && AUTO_SCROLL) begin
      page_d = ~page_q;
    end

    if (state_q == DISP_FAIL) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    // Blink restarts only when entering the fail mode, not on a repeat
    if (data_valid_i) begin
      cap_d = data_i;
      if (data_i == FAIL_WORD) begin
        state_d = DISP_FAIL;
        if (state_q != DISP_FAIL) begin
          bcnt_d  = '0;
          phase_d = 1'b1;
        end
      end else begin
        state_d = DISP_SHOW;
      end
    end
  end

  // Digit selection from the current registered state
  always_comb begin
    hex0_d = SEG_BLANK;
    hex1_d = SEG_BLANK;
    hex2_d = SEG_BLANK;
    hex3_d = SEG_BLANK;
    case (state_q)
      DISP_SHOW: begin
        hex0_d = seg0;
        hex1_d = seg1;
        hex2_d = seg2;
        hex3_d = seg3;
      end
      DISP_FAIL: begin
        if (phase_q) begin
          hex3_d = SEG_F;
          hex2_d = SEG_A;
          hex1_d = SEG_I;
          hex0_d = SEG_L;
        end
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISP_BLANK;
      cap_q   <= '0;
      page_q  <= 1'b0;
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      btn_q   <= 1'b0;
      hex0_o  <= SEG_BLANK;
      hex1_o  <= SEG_BLANK;
      hex2_o  <= SEG_BLANK;
      hex3_o  <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      page_q  <= page_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      btn_q   <= page_btn_i;
      hex0_o  <= hex0_d;
      hex1_o  <= hex1_d;
      hex2_o  <= hex2_d;
      hex3_o  <= hex3_d;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: two instances (manual paging and auto-scroll)
// driven by the same stimulus and compared against an elapsed-time model.
module tb_hex_display_ctrl;

  localparam int PT = 8;
  localparam int BT = 4;
  localparam logic [31:0] FW = 32'hFFFF_FFFF;
  localparam logic [27:0] BLANK4 = {4{7'b1111111}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] data = '0;
  logic        valid = 1'b0;
  logic        btn = 1'b0;
  logic [6:0]  a0, a1, a2, a3, b0, b1, b2, b3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_display_ctrl #(.PAGE_TICKS(PT), .BLINK_TICKS(BT), .AUTO_SCROLL(1'b0), .FAIL_WORD(FW)) dut_man (
    .clk(clk), .rst_n(rst_n), .data_i(data), .data_valid_i(valid), .page_btn_i(btn),
    .hex0_o(a0), .hex1_o(a1), .hex2_o(a2), .hex3_o(a3));

  hex_display_ctrl #(.PAGE_TICKS(PT), .BLINK_TICKS(BT), .AUTO_SCROLL(1'b1), .FAIL_WORD(FW)) dut_auto (
    .clk(clk), .rst_n(rst_n), .data_i(data), .data_valid_i(valid), .page_btn_i(btn),
    .hex0_o(b0), .hex1_o(b1), .hex2_o(b2), .hex3_o(b3));

  // Reference model: page and blink derived from elapsed cycle counts
  int          m_auto [2] = '{0, 1};
  int          m_seen [2];
  int          m_fail [2];
  logic [31:0] m_cap  [2];
  int          m_base [2];
  int          m_el   [2];
  int          m_ft   [2];
  int          m_prev_btn;

  function automatic logic [6:0] gl(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic int cur_page(input int i);
    return m_base[i] ^ (m_auto[i] != 0 ? (m_el[i] / PT) % 2 : 0);
  endfunction

  function automatic logic [27:0] model_disp(input int i);
    logic [15:0] h;
    if (m_seen[i] == 0) return BLANK4;
    if (m_fail[i] != 0) begin
      if ((m_ft[i] / BT) % 2 == 0) return {7'b0001110, 7'b0001000, 7'b1111001, 7'b1000111};
      return BLANK4;
    end
    h = (cur_page(i) != 0) ? m_cap[i][31:16] : m_cap[i][15:0];
    return {gl(h[15:12]), gl(h[11:8]), gl(h[7:4]), gl(h[3:0])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_seen[i] = 0; m_fail[i] = 0; m_cap[i] = '0;
      m_base[i] = 0; m_el[i] = 0; m_ft[i] = 0;
    end
    m_prev_btn = 0;
  endtask

  task automatic model_edge();
    int pg;
    int was_fail;
    for (int i = 0; i < 2; i++) begin
      pg = cur_page(i);
      if (btn && m_prev_btn == 0) begin
        m_base[i] = pg ^ 1;
        m_el[i]   = 0;
      end else if (m_seen[i] != 0) begin
        m_el[i]++;
      end
      was_fail = m_fail[i];
      if (was_fail != 0) m_ft[i]++;
      if (valid) begin
        m_cap[i]  = data;
        m_seen[i] = 1;
        if (data == FW) begin
          if (was_fail == 0) m_ft[i] = 0;
          m_fail[i] = 1;
        end else begin
          m_fail[i] = 0;
        end
      end
    end
    m_prev_btn = btn ? 1 : 0;
  endtask

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, then compare both instances
  task automatic step(input logic [31:0] d, input logic v, input logic b);
    logic [27:0] e0, e1;
    data = d; valid = v; btn = b;
    @(posedge clk);
    e0 = model_disp(0);
    e1 = model_disp(1);
    model_edge();
    #1;
    check("manual", {a3, a2, a1, a0}, e0);
    check("auto",   {b3, b2, b1, b0}, e1);
  endtask

  task automatic do_reset();
    valid = 1'b0; btn = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_manual", {a3, a2, a1, a0}, BLANK4);
    check("reset_auto",   {b3, b2, b1, b0}, BLANK4);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] last;
    logic        bl;
    #2;
    do_reset();

    // Idle after reset stays blank
    for (int k = 0; k < 10; k++) step('0, 1'b0, 1'b0);

    // Manual paging of 1234_ABCD
    step(32'h1234_ABCD, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    check("low_half", {a3, a2, a1, a0},
          {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001});
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    check("high_half", {a3, a2, a1, a0},
          {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    for (int k = 0; k < 12; k++) step('0, 1'b0, 1'b0);

    // Auto-scroll with a button edge landing on the wrap cycle
    do_reset();
    step(32'h0000_FFFF, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step('0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) step('0, 1'b0, 1'b0);

    // Blinking fail message, repeated sentinel does not restart it
    step(FW, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) step('0, 1'b0, 1'b0);
    step(FW, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) step('0, 1'b0, 1'b0);

    // Leave fail mode with a normal value
    step(32'h0000_0042, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step('0, 1'b0, 1'b0);

    // Reset mid-blink, then stays blank until a new strobe
    step(FW, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) step('0, 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < 5; k++) step('0, 1'b0, 1'b0);

    // Randomised traffic
    last = 32'h0BAD_F00D;
    bl = 1'b0;
    for (int k = 0; k < 600; k++) begin
      logic [31:0] d;
      logic        v;
      int          r;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        bl = 1'b0;
      end
      v = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 3);
      d = (r == 0) ? FW : (r == 1) ? last : $urandom;
      if (v) last = d;
      if ($urandom_range(0, 5) == 0) bl = ~bl;
      step(d, v, bl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
